// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU result path.
//   ALU_ADD..ALU_NOR : 3-bit command encodings
//   occ_t            : skid-buffer occupancy (EMPTY, ONE, FULL)
//   alu_result_t     : one captured ALU result {cmd, data, carryout, overflow, zero}
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_NAND = 3'd5;
  localparam logic [2:0] ALU_OR   = 3'd6;
  localparam logic [2:0] ALU_NOR  = 3'd7;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  typedef struct packed {
    logic [2:0]            cmd;
    logic [ALU_DATA_W-1:0] data;
    logic                  carryout;
    logic                  overflow;
    logic                  zero;
  } alu_result_t;

endpackage

// File: rtl/alu_result_entry.sv
// alu_result_entry: one load-enabled alu_result_t register.
//   clk, rst_n : clock, async active-low reset (clears to 0)
//   load       : capture d on the rising edge
//   d, q       : next / held result
module alu_result_entry
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  alu_result_t d,
  output alu_result_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered result stage after the 32-bit ALU.
// Two-entry skid buffer (main = head, skid = overflow) behind a valid/ready
// handshake; in_ready is a pure function of the registered occupancy.
//   in_*          : ALU result + command, in_valid/in_ready handshake
//   out_*         : head result, out_valid/out_ready handshake; out_neg = data MSB
//   result_count  : number of popped results, wrapping
// Optional (macro ALU_STICKY_FLAGS_EN): sticky_clr in, sticky_overflow and
// sticky_carry out; set on a pop whose head flag is 1, set beats clear.
//
// state | meaning
// EMPTY | nothing held, out_valid=0
// ONE   | head valid in main, skid free
// FULL  | main and skid both valid, in_ready=0
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_cmd,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_carryout,
  input  logic              in_overflow,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_cmd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_carryout,
  output logic              out_overflow,
  output logic              out_zero,
  output logic              out_neg,
`ifdef ALU_STICKY_FLAGS_EN
  input  logic              sticky_clr,
  output logic              sticky_overflow,
  output logic              sticky_carry,
`endif
  output logic [CNT_W-1:0]  result_count
);

  occ_t        occState, occNext;
  alu_result_t inEntry, mainD, mainQ, skidQ;
  logic        accept, pop, mainLoad, skidLoad, mainFromSkid;
  logic [CNT_W-1:0] resultCount;

  assign inEntry = '{cmd: in_cmd, data: in_data, carryout: in_carryout,
                     overflow: in_overflow, zero: in_zero};

  assign in_ready  = (occState != FULL);
  assign out_valid = (occState != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occState <= EMPTY;
    end else begin
      occState <= occNext;
    end
  end

  always_comb begin
    occNext      = occState;
    mainLoad     = 1'b0;
    skidLoad     = 1'b0;
    mainFromSkid = 1'b0;
    unique case (occState)
      EMPTY: begin
        if (accept) begin
          occNext  = ONE;
          mainLoad = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          mainLoad = 1'b1;
        end else if (accept) begin
          occNext  = FULL;
          skidLoad = 1'b1;
        end else if (pop) begin
          occNext = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          occNext      = ONE;
          mainLoad     = 1'b1;
          mainFromSkid = 1'b1;
        end
      end
      default: occNext = EMPTY;
    endcase
  end

  assign mainD = mainFromSkid ? skidQ : inEntry;

  alu_result_entry uMain (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (mainLoad),
    .d     (mainD),
    .q     (mainQ)
  );

  alu_result_entry uSkid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skidLoad),
    .d     (inEntry),
    .q     (skidQ)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resultCount <= '0;
    end else if (pop) begin
      resultCount <= resultCount + CNT_W'(1);
    end
  end

`ifdef ALU_STICKY_FLAGS_EN
  logic stickyOvf, stickyCarry;

  // Set is checked first so a pop with the flag wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stickyOvf   <= 1'b0;
      stickyCarry <= 1'b0;
    end else begin
      if (pop && mainQ.overflow) stickyOvf <= 1'b1;
      else if (sticky_clr)       stickyOvf <= 1'b0;
      if (pop && mainQ.carryout) stickyCarry <= 1'b1;
      else if (sticky_clr)       stickyCarry <= 1'b0;
    end
  end

  assign sticky_overflow = stickyOvf;
  assign sticky_carry    = stickyCarry;
`endif

  assign out_cmd      = mainQ.cmd;
  assign out_data     = mainQ.data;
  assign out_carryout = mainQ.carryout;
  assign out_overflow = mainQ.overflow;
  assign out_zero     = mainQ.zero;
  assign out_neg      = mainQ.data[DATA_W-1];
  assign result_count = resultCount;

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage: driver pushes expected results into a
// scoreboard queue on each accept; a monitor pops and compares on each pop
// and verifies the head is held while stalled.
module tb_alu_result_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_cmd = '0;
  logic [31:0] in_data = '0;
  logic        in_carryout = 1'b0, in_overflow = 1'b0, in_zero = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  out_cmd;
  logic [31:0] out_data;
  logic        out_carryout, out_overflow, out_zero, out_neg;
  logic [15:0] result_count;
`ifdef ALU_STICKY_FLAGS_EN
  logic        sticky_clr = 1'b0;
  logic        sticky_overflow, sticky_carry;
`endif

  alu_result_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_data(in_data),
    .in_carryout(in_carryout), .in_overflow(in_overflow), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd), .out_data(out_data),
    .out_carryout(out_carryout), .out_overflow(out_overflow), .out_zero(out_zero),
    .out_neg(out_neg),
`ifdef ALU_STICKY_FLAGS_EN
    .sticky_clr(sticky_clr), .sticky_overflow(sticky_overflow), .sticky_carry(sticky_carry),
`endif
    .result_count(result_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  alu_result_t expQ[$];
  logic [15:0] expCount = '0;
  bit          randOut = 1'b0;
  bit          held = 1'b0;
  alu_result_t heldVal;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic alu_result_t headNow();
    return '{cmd: out_cmd, data: out_data, carryout: out_carryout,
             overflow: out_overflow, zero: out_zero};
  endfunction

  // Monitor: sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    alu_result_t exp;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_hold", 64'(headNow()), 64'(heldVal));
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          chk("unexpected_pop", 64'd1, 64'd0);
        end else begin
          exp = expQ.pop_front();
          chk("pop_result", 64'(headNow()), 64'(exp));
          chk("pop_neg", 64'(out_neg), 64'(exp.data[31]));
          chk("pop_count", 64'(result_count), 64'(expCount));
          expCount = expCount + 16'd1;
        end
      end else if (out_valid) begin
        held = 1'b1;
        heldVal = headNow();
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (randOut) out_ready = ($urandom_range(0, 1) == 1);
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic push(input logic [2:0] cmd, input logic [31:0] data,
                      input logic c, input logic o, input logic z, output int waited);
    alu_result_t item;
    item = '{cmd: cmd, data: data, carryout: c, overflow: o, zero: z};
    in_cmd = cmd; in_data = data; in_carryout = c; in_overflow = o; in_zero = z;
    in_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      waited++;
      if (in_ready) begin
        expQ.push_back(item);
        break;
      end
      if (waited > 1000) begin
        chk("push_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (expQ.size() != 0 && n < 5000) begin
      @(posedge clk); n++;
    end
    #1;
    chk("drain_empty", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    int w, sumW;
    logic [15:0] startCount;

    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_count", 64'(result_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(1);

    // single ADD result, one cycle latency
    out_ready = 1'b1;
    push(ALU_ADD, 32'h5, 1'b0, 1'b0, 1'b0, w);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_data", 64'(out_data), 64'd5);
    chk("t1_cmd", 64'(out_cmd), 64'd0);
    cycles(1);
    chk("t1_count", 64'(result_count), 64'd1);

    // fill to FULL while stalled
    out_ready = 1'b0;
    push(ALU_SUB, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, w);
    push(ALU_XOR, 32'h0, 1'b0, 1'b0, 1'b1, w);
    chk("t2_in_ready_low", 64'(in_ready), 64'd0);
    chk("t2_head", 64'(out_data), 64'hFFFF_FFFF);
    chk("t2_neg", 64'(out_neg), 64'd1);
    cycles(3);
    chk("t2_still_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    cycles(1);
    chk("t2_in_ready_back", 64'(in_ready), 64'd1);
    chk("t2_second", 64'(out_data), 64'h0);
    drain();
    chk("t2_count", 64'(result_count), 64'd3);

    // back-to-back stream, no bubbles
    startCount = result_count;
    sumW = 0;
    for (int i = 1; i <= 100; i++) begin
      push(ALU_ADD, 32'(i), 1'b0, 1'b0, 1'b0, w);
      sumW += w;
    end
    chk("t3_no_bubbles", 64'(sumW), 64'd100);
    drain();
    chk("t3_count", 64'(result_count), 64'(startCount + 16'd100));

    // random backpressure and random input gaps
    randOut = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) cycles(1);
      push(3'($urandom_range(0, 7)), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), w);
    end
    randOut = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("t4_count", 64'(result_count), 64'(expCount));

    // async reset while FULL; in_valid held during reset
    out_ready = 1'b0;
    push(ALU_OR, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, w);
    push(ALU_NOR, 32'h8000_0000, 1'b0, 1'b1, 1'b0, w);
    chk("t5_full", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_data", 64'(out_data), 64'd0);
    chk("t5_rst_count", 64'(result_count), 64'd0);
    expQ.delete();
    expCount = '0;
    cycles(3);
    in_valid = 1'b0;
    rst_n = 1'b1;
    cycles(1);
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    chk("t5_out_valid", 64'(out_valid), 64'd0);

`ifdef ALU_STICKY_FLAGS_EN
    out_ready = 1'b1;
    push(ALU_ADD, 32'h1, 1'b0, 1'b1, 1'b0, w);
    cycles(1);
    chk("s_ovf_set", 64'(sticky_overflow), 64'd1);
    chk("s_carry_clear", 64'(sticky_carry), 64'd0);
    push(ALU_ADD, 32'h2, 1'b1, 1'b1, 1'b0, w);
    sticky_clr = 1'b1;
    cycles(1);
    sticky_clr = 1'b0;
    chk("s_set_wins", 64'(sticky_overflow), 64'd1);
    chk("s_carry_set", 64'(sticky_carry), 64'd1);
    sticky_clr = 1'b1;
    cycles(1);
    sticky_clr = 1'b0;
    chk("s_clr_ovf", 64'(sticky_overflow), 64'd0);
    chk("s_clr_carry", 64'(sticky_carry), 64'd0);
    drain();
`endif

    cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
